// File: rtl/ro_sweep_ctrl.sv
// Ring-oscillator PUF sweep controller.
// Each challenge pair is measured as two back-to-back RO windows. The two
// captured counts are compared into one response bit, and ties are counted.
// When the sweep finishes, a hash engine is kicked off. The packed response
// becomes visible only when the hash engine completes.
module ro_sweep_ctrl #(
   parameter int NUM_PAIRS   = 8,
   parameter int WINDOW      = 1000,
   parameter int CLR_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [7:0]           base_chal,
   output logic [7:0]           chal,
   output logic                 puf_en,
   output logic                 puf_clr,
   input  logic                 clr_done,
   input  logic [7:0]           key,
   output logic                 hash_start,
   input  logic                 hash_ready,
   output logic [NUM_PAIRS-1:0] resp,
   output logic [3:0]           tie_cnt,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int NMEAS = 2 * NUM_PAIRS;
   // Measurement index width. At least 2 bits, so the pair index slice below is never empty.
   localparam int MW    = (NUM_PAIRS < 2) ? 2 : $clog2(NMEAS);
   // One shared timer serves the window, settle and clear-timeout phases.
   localparam int TMAX  = (WINDOW > CLR_TIMEOUT) ? WINDOW : CLR_TIMEOUT;
   localparam int CW    = (TMAX < 2) ? 2 : $clog2(TMAX);

   localparam logic [MW-1:0] M_LAST   = MW'(NMEAS - 1);
   localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(CLR_TIMEOUT - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT_CLR,
      S_MEASURE,
      S_SETTLE,
      S_CAPTURE,
      S_HASH,
      S_DONE,
      S_ERROR
   } state_t;

   state_t               state_q, state_d;
   logic [MW-1:0]        m_q, m_d;
   logic [7:0]           base_q, base_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [7:0]           key_a_q, key_a_d;
   logic [NUM_PAIRS-1:0] part_q, part_d;
   logic [NUM_PAIRS-1:0] resp_q, resp_d;
   logic [3:0]           tie_q, tie_d;
   logic                 hs_q, hs_d;
   logic [MW-2:0]        pair_idx;

   // The pair index is m/2. Odd measurements close a pair.
   assign pair_idx = m_q[MW-1:1];

   // Next-state logic. Abort overrides every transition, including a start.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      key_a_d = key_a_q;
      part_d  = part_q;
      resp_d  = resp_q;
      tie_d   = tie_q;
      hs_d    = 1'b0;

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         m_d     = '0;
         base_d  = '0;
         cnt_d   = '0;
         part_d  = '0;
         resp_d  = '0;
         tie_d   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start && !abort) begin
                  state_d = S_CLEAR;
                  base_d  = base_chal;
                  m_d     = '0;
                  cnt_d   = '0;
                  part_d  = '0;
                  resp_d  = '0;
                  tie_d   = '0;
               end
            end
            S_CLEAR: begin
               state_d = S_WAIT_CLR;
               cnt_d   = '0;
            end
            S_WAIT_CLR: begin
               if (clr_done) begin
                  state_d = S_MEASURE;
                  cnt_d   = '0;
               end else if (cnt_q == TO_LAST) begin
                  state_d = S_ERROR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_MEASURE: begin
               if (cnt_q == WIN_LAST) begin
                  state_d = S_SETTLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_SETTLE: begin
               if (cnt_q == SET_LAST) begin
                  state_d = S_CAPTURE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_CAPTURE: begin
               if (!m_q[0]) begin
                  key_a_d = key;
               end else begin
                  part_d[pair_idx] = (key_a_q > key);
                  if ((key_a_q == key) && (tie_q != 4'hF))
                     tie_d = tie_q + 4'd1;
               end
               if (m_q == M_LAST) begin
                  state_d = S_HASH;
                  hs_d    = 1'b1;
               end else begin
                  state_d = S_CLEAR;
                  m_d     = m_q + MW'(1);
               end
            end
            S_HASH: begin
               if (hash_ready) begin
                  state_d = S_DONE;
                  resp_d  = part_q;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers, with a synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         base_q  <= '0;
         cnt_q   <= '0;
         key_a_q <= '0;
         part_q  <= '0;
         resp_q  <= '0;
         tie_q   <= '0;
         hs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         key_a_q <= key_a_d;
         part_q  <= part_d;
         resp_q  <= resp_d;
         tie_q   <= tie_d;
         hs_q    <= hs_d;
      end
   end

   // Enables drop in the abort cycle itself. CLEAR and MEASURE are disjoint states.
   assign chal       = base_q + {{(8-MW){1'b0}}, m_q};
   assign puf_en     = (state_q == S_MEASURE) && !abort;
   assign puf_clr    = (state_q == S_CLEAR) && !abort;
   assign hash_start = hs_q;
   assign resp       = resp_q;
   assign tie_cnt    = tie_q;
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
   assign done       = (state_q == S_DONE);
   assign err        = (state_q == S_ERROR);

endmodule

// File: tb/tb_ro_sweep_ctrl.sv
// Bench for ro_sweep_ctrl. Two instances are used: a small 2-pair one and a 16-pair one.
module tb_ro_sweep_ctrl;
   localparam int NPA = 2,  WA = 4, TOA = 12;
   localparam int NPB = 16, WB = 3, TOB = 20;
   localparam int LIMIT = 3000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [1:0]      start, abort, clr_done, hash_ready;
   logic [1:0][7:0] base_chal, key, chal;
   logic [1:0]      puf_en, puf_clr, hash_start, busy, done, err;
   logic [1:0][3:0] tie_cnt;
   logic [NPA-1:0]  resp_a;
   logic [NPB-1:0]  resp_b;
   logic [1:0][15:0] resp_w;

   // Key source: each RO challenge maps to a fixed count in a per-instance table.
   logic [7:0] ktab [2][256];
   assign key[0]    = ktab[0][chal[0]];
   assign key[1]    = ktab[1][chal[1]];
   assign resp_w[0] = 16'(resp_a);
   assign resp_w[1] = resp_b;

   ro_sweep_ctrl #(.NUM_PAIRS(NPA), .WINDOW(WA), .CLR_TIMEOUT(TOA)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
      .base_chal(base_chal[0]), .chal(chal[0]), .puf_en(puf_en[0]), .puf_clr(puf_clr[0]),
      .clr_done(clr_done[0]), .key(key[0]), .hash_start(hash_start[0]),
      .hash_ready(hash_ready[0]), .resp(resp_a), .tie_cnt(tie_cnt[0]),
      .busy(busy[0]), .done(done[0]), .err(err[0]));

   ro_sweep_ctrl #(.NUM_PAIRS(NPB), .WINDOW(WB), .CLR_TIMEOUT(TOB)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
      .base_chal(base_chal[1]), .chal(chal[1]), .puf_en(puf_en[1]), .puf_clr(puf_clr[1]),
      .clr_done(clr_done[1]), .key(key[1]), .hash_start(hash_start[1]),
      .hash_ready(hash_ready[1]), .resp(resp_b), .tie_cnt(tie_cnt[1]),
      .busy(busy[1]), .done(done[1]), .err(err[1]));

   int n_chk = 0, n_fail = 0;

   // Counter/hash responders. clr_done arrives clr_lat cycles after puf_clr.
   // hash_ready arrives hash_lat cycles after hash_start.
   int clr_lat[2] = '{1, 1}, hash_lat[2] = '{3, 3};
   int clr_wait[2] = '{0, 0}, hash_wait[2] = '{0, 0};
   logic [1:0] clr_block = '0;
   initial begin
      clr_done = '0;
      hash_ready = '0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            clr_done[d] = 1'b0;
            hash_ready[d] = 1'b0;
            if (clr_wait[d] > 0) begin
               clr_wait[d]--;
               if (clr_wait[d] == 0) clr_done[d] = 1'b1;
            end
            if (hash_wait[d] > 0) begin
               hash_wait[d]--;
               if (hash_wait[d] == 0) hash_ready[d] = 1'b1;
            end
            if (puf_clr[d] === 1'b1 && !clr_block[d]) clr_wait[d] = clr_lat[d];
            if (hash_start[d] === 1'b1) hash_wait[d] = hash_lat[d];
         end
      end
   end

   // Protocol monitor: records window lengths, challenges, pulse counts and overlaps.
   int en_run[2], win_cnt[2], win_bad[2], ovl[2], hs_cnt[2], clr_cnt[2], clr_wide[2];
   int chal_bad[2], resp_early[2], chal_n[2];
   logic [7:0] chal_log [2][64];
   logic [1:0] clr_prev = '0;
   logic [1:0][7:0] win_chal;
   initial forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         if (puf_en[d] === 1'b1) begin
            if (en_run[d] == 0) begin
               win_chal[d] = chal[d];
               if (chal_n[d] < 64) chal_log[d][chal_n[d]] = chal[d];
               chal_n[d]++;
            end else if (chal[d] !== win_chal[d]) chal_bad[d]++;
            en_run[d]++;
         end else if (en_run[d] > 0) begin
            win_cnt[d]++;
            if (en_run[d] != ((d == 0) ? WA : WB)) win_bad[d]++;
            en_run[d] = 0;
         end
         if (puf_en[d] === 1'b1 && puf_clr[d] === 1'b1) ovl[d]++;
         if (puf_clr[d] === 1'b1) begin
            clr_cnt[d]++;
            if (clr_prev[d]) clr_wide[d]++;
         end
         clr_prev[d] = (puf_clr[d] === 1'b1);
         if (hash_start[d] === 1'b1) hs_cnt[d]++;
         if (done[d] !== 1'b1 && resp_w[d] !== 16'h0) resp_early[d]++;
      end
   end

   task automatic clear_mon(input int d);
      en_run[d] = 0; win_cnt[d] = 0; win_bad[d] = 0; ovl[d] = 0; hs_cnt[d] = 0;
      clr_cnt[d] = 0; clr_wide[d] = 0; chal_bad[d] = 0; resp_early[d] = 0; chal_n[d] = 0;
   endtask

   // Reference: pair i compares table entries at base+2i and base+2i+1 (mod 256).
   task automatic model(input int d, input logic [7:0] base, output logic [15:0] er,
                        output logic [3:0] et);
      int np, t;
      logic [7:0] ka, kb;
      np = (d == 0) ? NPA : NPB;
      er = '0;
      t  = 0;
      for (int i = 0; i < np; i++) begin
         ka = ktab[d][8'(base + 2*i)];
         kb = ktab[d][8'(base + 2*i + 1)];
         if (ka > kb) er[i] = 1'b1;
         if (ka == kb && t < 15) t++;
      end
      et = 4'(t);
   endtask

   // Full sweep from whatever resting state the instance is in, checked against the model.
   task automatic run_sweep(input int d, input logic [7:0] base, input string tag);
      logic [15:0] er;
      logic [3:0]  et;
      int np, n;
      bit ok;
      np = (d == 0) ? NPA : NPB;
      model(d, base, er, et);
      clear_mon(d);
      @(posedge clk); #1;
      base_chal[d] = base;
      start[d] = 1'b1;
      @(posedge clk); #1;
      start[d] = 1'b0;
      base_chal[d] = 8'($urandom);
      n_chk++;
      if ({busy[d], err[d], done[d], puf_clr[d]} !== 4'b1001) begin
         n_fail++;
         $display("FAIL %s start_status: busy/err/done/clr=%b want 1001", tag,
                  {busy[d], err[d], done[d], puf_clr[d]});
      end
      n = 0;
      while (done[d] !== 1'b1 && n < LIMIT) begin
         @(posedge clk); #1;
         n++;
      end
      n_chk++;
      if (done[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done_timeout: done=%b after %0d cycles", tag, done[d], n);
      end
      n_chk++;
      if (resp_w[d] !== er) begin
         n_fail++;
         $display("FAIL %s resp: got %h want %h", tag, resp_w[d], er);
      end
      n_chk++;
      if (tie_cnt[d] !== et) begin
         n_fail++;
         $display("FAIL %s tie_cnt: got %0d want %0d", tag, tie_cnt[d], et);
      end
      n_chk++;
      if (hs_cnt[d] != 1) begin
         n_fail++;
         $display("FAIL %s hash_start_count: got %0d want 1", tag, hs_cnt[d]);
      end
      n_chk++;
      if (win_cnt[d] != 2*np || clr_cnt[d] != 2*np) begin
         n_fail++;
         $display("FAIL %s window_count: windows=%0d clears=%0d want %0d", tag,
                  win_cnt[d], clr_cnt[d], 2*np);
      end
      n_chk++;
      if (win_bad[d] + ovl[d] + clr_wide[d] + chal_bad[d] + resp_early[d] != 0) begin
         n_fail++;
         $display("FAIL %s protocol: badlen=%0d overlap=%0d wideclr=%0d chalmove=%0d early_resp=%0d want all 0",
                  tag, win_bad[d], ovl[d], clr_wide[d], chal_bad[d], resp_early[d]);
      end
      ok = (chal_n[d] == 2*np);
      for (int m = 0; m < 2*np && m < 64; m++)
         if (chal_log[d][m] !== 8'(base + m)) ok = 1'b0;
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s chal_seq: %0d windows, first chal %h want base %h +m", tag,
                  chal_n[d], chal_log[d][0], base);
      end
      n_chk++;
      if (busy[d] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy_in_done: got %b want 0", tag, busy[d]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({chal[d], puf_en[d], puf_clr[d], hash_start[d], busy[d], done[d], err[d],
              tie_cnt[d], resp_w[d]} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: chal=%h en=%b clr=%b hs=%b busy=%b done=%b err=%b tie=%0d resp=%h want all 0",
                     d, chal[d], puf_en[d], puf_clr[d], hash_start[d], busy[d], done[d],
                     err[d], tie_cnt[d], resp_w[d]);
         end
      end
      rst_n = 1'b1;
      clear_mon(0);
      clear_mon(1);
   endtask

   task automatic test_directed();
      ktab[0][8'h10] = 8'd50;
      ktab[0][8'h11] = 8'd30;
      ktab[0][8'h12] = 8'd20;
      ktab[0][8'h13] = 8'd40;
      clr_lat[0] = 1;
      hash_lat[0] = 3;
      run_sweep(0, 8'h10, "directed");
      n_chk++;
      if (resp_w[0] !== 16'h0001 || tie_cnt[0] !== 4'd0) begin
         n_fail++;
         $display("FAIL directed_const: resp=%h tie=%0d want 0001/0", resp_w[0], tie_cnt[0]);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_c [4];
      exp_c[0] = 8'hFE; exp_c[1] = 8'hFF; exp_c[2] = 8'h00; exp_c[3] = 8'h01;
      run_sweep(0, 8'hFE, "wrap");
      for (int m = 0; m < 4; m++) begin
         n_chk++;
         if (chal_log[0][m] !== exp_c[m]) begin
            n_fail++;
            $display("FAIL wrap_chal[%0d]: got %h want %h", m, chal_log[0][m], exp_c[m]);
         end
      end
   endtask

   // Consecutive sweeps, each started straight from DONE, with random keys and latencies.
   task automatic test_back_to_back();
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < 256; i++) ktab[0][i] = 8'($urandom_range(0, 3));
         clr_lat[0]  = $urandom_range(1, 4);
         hash_lat[0] = $urandom_range(1, 6);
         run_sweep(0, 8'($urandom), "b2b");
      end
   endtask

   task automatic test_timeout();
      int n;
      clr_block[0] = 1'b1;
      clear_mon(0);
      @(posedge clk); #1;
      start[0] = 1'b1;
      base_chal[0] = 8'h33;
      @(posedge clk); #1;
      start[0] = 1'b0;
      n = 0;
      while (err[0] !== 1'b1 && n < LIMIT) begin
         @(posedge clk); #1;
         n++;
      end
      n_chk++;
      if (n != TOA + 1) begin
         n_fail++;
         $display("FAIL timeout_latency: err after %0d cycles want %0d", n, TOA + 1);
      end
      repeat (5) @(posedge clk);
      #1;
      n_chk++;
      if ({err[0], busy[0], puf_en[0], done[0]} !== 4'b1000 || win_cnt[0] != 0) begin
         n_fail++;
         $display("FAIL timeout_hold: err/busy/en/done=%b windows=%0d want 1000/0",
                  {err[0], busy[0], puf_en[0], done[0]}, win_cnt[0]);
      end
      clr_block[0] = 1'b0;
      clr_lat[0] = 2;
      run_sweep(0, 8'h80, "after_err");
   endtask

   task automatic test_abort();
      int n;
      clr_lat[0] = 1;
      clear_mon(0);
      @(posedge clk); #1;
      start[0] = 1'b1;
      base_chal[0] = 8'h5A;
      @(posedge clk); #1;
      start[0] = 1'b0;
      n = 0;
      while (puf_en[0] !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      n_chk++;
      if (puf_en[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_reach_measure: puf_en=%b want 1", puf_en[0]);
      end
      repeat ($urandom_range(0, WA - 2)) @(posedge clk);
      #1;
      abort[0] = 1'b1;
      start[0] = 1'b1;
      #1;
      n_chk++;
      if (puf_en[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_en_same_cycle: puf_en=%b want 0", puf_en[0]);
      end
      @(posedge clk); #1;
      abort[0] = 1'b0;
      start[0] = 1'b0;
      n_chk++;
      if ({busy[0], done[0], err[0], puf_en[0], puf_clr[0], hash_start[0]} !== 6'b0 ||
          chal[0] !== 8'h00 || resp_w[0] !== 16'h0 || tie_cnt[0] !== 4'd0) begin
         n_fail++;
         $display("FAIL abort_idle: busy=%b done=%b err=%b en=%b clr=%b chal=%h resp=%h want idle zeros",
                  busy[0], done[0], err[0], puf_en[0], puf_clr[0], chal[0], resp_w[0]);
      end
      clear_mon(0);
      repeat (30) @(posedge clk);
      #1;
      n_chk++;
      if (hs_cnt[0] != 0 || clr_cnt[0] != 0 || win_cnt[0] != 0 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_stays_idle: hs=%0d clr=%0d win=%0d busy=%b want 0",
                  hs_cnt[0], clr_cnt[0], win_cnt[0], busy[0]);
      end
   endtask

   task automatic test_reset_in_hash();
      int n;
      hash_lat[0] = 40;
      clr_lat[0] = 1;
      clear_mon(0);
      @(posedge clk); #1;
      start[0] = 1'b1;
      base_chal[0] = 8'hC0;
      @(posedge clk); #1;
      start[0] = 1'b0;
      n = 0;
      while (hash_start[0] !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      n_chk++;
      if (hash_start[0] !== 1'b1 || busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_reach_hash: hash_start=%b busy=%b want 1/1", hash_start[0], busy[0]);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if ({chal[0], puf_en[0], puf_clr[0], hash_start[0], busy[0], done[0], err[0],
           tie_cnt[0], resp_w[0]} !== 34'h0) begin
         n_fail++;
         $display("FAIL rst_in_hash: chal=%h en=%b clr=%b hs=%b busy=%b done=%b err=%b want all 0",
                  chal[0], puf_en[0], puf_clr[0], hash_start[0], busy[0], done[0], err[0]);
      end
      rst_n = 1'b1;
      clear_mon(0);
      repeat (50) @(posedge clk);
      #1;
      n_chk++;
      if (hs_cnt[0] != 0 || clr_cnt[0] != 0 || done[0] !== 1'b0 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_no_activity: hs=%0d clr=%0d done=%b busy=%b want 0",
                  hs_cnt[0], clr_cnt[0], done[0], busy[0]);
      end
      hash_lat[0] = 3;
   endtask

   task automatic test_tie_saturate();
      logic [7:0] v;
      v = 8'($urandom);
      for (int i = 0; i < 256; i++) ktab[1][i] = v;
      clr_lat[1] = 1;
      run_sweep(1, 8'($urandom), "tie16");
      n_chk++;
      if (resp_w[1] !== 16'h0 || tie_cnt[1] !== 4'd15) begin
         n_fail++;
         $display("FAIL tie_saturate: resp=%h tie=%0d want 0000/15", resp_w[1], tie_cnt[1]);
      end
   endtask

   task automatic test_random_wide();
      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < 256; i++) ktab[1][i] = 8'($urandom_range(0, 7));
         clr_lat[1]  = $urandom_range(1, 3);
         hash_lat[1] = $urandom_range(1, 5);
         run_sweep(1, 8'($urandom), "rand16");
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = '0;
      abort = '0;
      base_chal = '0;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 256; i++) ktab[d][i] = 8'($urandom);
      test_reset();
      test_directed();
      test_wrap();
      test_back_to_back();
      test_timeout();
      test_abort();
      test_reset_in_hash();
      test_tie_saturate();
      test_random_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ro_sweep_ctrl.md
RO_SWEEP_CTRL -- requirements
Module: ro_sweep_ctrl

Interface
REQ-001 SHALL have parameter NUM_PAIRS, default 8, meaning challenge pairs per sweep and response width (1..16).
REQ-002 SHALL have parameter WINDOW, default 1000, meaning RO measurement window in clk cycles (>=1).
REQ-003 SHALL have parameter CLR_TIMEOUT, default 255, meaning max cycles to wait for clr_done.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  begin sweep; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  terminate sweep; return to IDLE.
REQ-008 SHALL have port base_chal  input  8  first challenge; sampled on accepted start.
REQ-009 SHALL have port chal  output  8  challenge driven to the RO array/mux.
REQ-010 SHALL have port puf_en  output  1  RO/counter enable.
REQ-011 SHALL have port puf_clr  output  1  counter/buffer clear pulse.
REQ-012 SHALL have port clr_done  input  1  clear acknowledge from standard counter.
REQ-013 SHALL have port key  input  8  captured 8-bit RO count.
REQ-014 SHALL have port hash_start  output  1  one-cycle hash start pulse.
REQ-015 SHALL have port hash_ready  input  1  hash completion.
REQ-016 SHALL have port resp  output  NUM_PAIRS  packed response bits.
REQ-017 SHALL have port tie_cnt  output  4  count of equal-key pairs, saturating at 15.
REQ-018 SHALL have ports busy, done, err  output  1 each  status.

Function
REQ-019 SHALL implement states IDLE, CLEAR, WAIT_CLR, MEASURE, SETTLE, CAPTURE, HASH, DONE, ERROR.
REQ-020 IDLE: start=1 -> CLEAR; latch base_chal; clear meas index m, resp, tie_cnt; busy=1 from next cycle.
REQ-021 Measurement m (0..2*NUM_PAIRS-1) SHALL use chal = base_chal + m, modulo 256 (wraps 8'hFF -> 8'h00).
REQ-022 CLEAR: puf_clr=1 for exactly one cycle, then WAIT_CLR.
REQ-023 WAIT_CLR: clr_done=1 -> MEASURE; CLR_TIMEOUT cycles without clr_done -> ERROR.
REQ-024 MEASURE: puf_en=1 for exactly WINDOW consecutive cycles, then SETTLE; chal stable throughout.
REQ-025 SETTLE: puf_en=0 for 2 cycles, then CAPTURE.
REQ-026 CAPTURE (1 cycle): even m stores key in key_a; odd m compares key against key_a.
REQ-027 Odd m: resp[m/2] = (key_a > key) unsigned; key_a == key -> bit 0 and tie_cnt+1 (saturate at 15).
REQ-028 After CAPTURE: m < 2*NUM_PAIRS-1 -> m+1, CLEAR; else HASH with hash_start=1 for one cycle on entry.
REQ-029 HASH: wait hash_ready=1 -> DONE; hash_start never re-asserted within a sweep.
REQ-030 DONE: done=1, busy=0; resp/tie_cnt held; start=1 -> new sweep as from IDLE; else stay.
REQ-031 ERROR: err=1, busy=0, puf_en=0; held until start=1 (clears err, starts sweep) or reset.
REQ-032 abort=1 in any state except IDLE -> IDLE next cycle; puf_en=0 that cycle; resp zeroed; done=0; abort has priority over all transitions including start.
REQ-033 resp SHALL be zero until DONE; partial bits internal only.
REQ-034 puf_clr and puf_en SHALL never be 1 in the same cycle.

Reset
REQ-035 rst_n=0 at a clock edge SHALL force IDLE, m=0, chal=0, puf_en=0, puf_clr=0, hash_start=0, resp=0, tie_cnt=0, busy=0, done=0, err=0.
REQ-036 Reset mid-sweep SHALL take effect the same edge; no further hash_start or puf_clr issued.

Verification
REQ-037 NUM_PAIRS=2, WINDOW=4, base_chal=8'h10, clr_done one cycle after puf_clr, keys 50,30,20,40 -> chal 10,11,12,13; resp=2'b01; tie_cnt=0; one hash_start; done after hash_ready.
REQ-038 Measure puf_en: high exactly WINDOW cycles per measurement, 2*NUM_PAIRS windows per sweep, never overlapping puf_clr.
REQ-039 base_chal=8'hFE, NUM_PAIRS=2 -> chal sequence FE, FF, 00, 01.
REQ-040 clr_done held 0 -> err=1 after CLR_TIMEOUT cycles, puf_en=0; start clears err and restarts.
REQ-041 Equal keys in all pairs, NUM_PAIRS=16 -> resp=0, tie_cnt saturates at 15.
REQ-042 abort during MEASURE, and rst_n=0 during HASH -> IDLE next cycle, outputs at reset/idle values, no hash_start.
